stripe_scanline_detector: RTL and testbench
===========================================

# stripe_scanline_detector

Streaming zebra-crossing detector that replaces the frame-buffer-plus-search path with a single pass over the pixel stream. It thresholds each incoming pixel and measures run lengths on `NUM_LINES` scan rows spaced evenly through the frame. At end of frame it evaluates every scan row and reports a crossing decision, so no image BRAM is needed. It sits downstream of `convolution_filter` and consumes its `y_*` stream directly.

## Interface
- `IMG_WIDTH`, 640: pixels per row.
- `IMG_HEIGHT`, 480: rows per frame.
- `W`, 8: pixel width.
- `NUM_LINES`, 4: number of scan rows, 1..IMG_HEIGHT-1.
- `MIN_RUN`, 8: minimum run of 1-pixels that counts as a stripe.
- `MIN_STRIPES`, 4: lower bound of a plausible per-line stripe count.
- `MAX_STRIPES`, 12: upper bound of a plausible per-line stripe count.
- `MIN_AGREE`, 3: number of lines in range required to declare a crossing.
- `CNT_W`, 8: stripe counter width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `x_valid`  in  1  pixel valid.
- `x_ready`  out  1  pixel accepted when `x_valid && x_ready`.
- `x_data`  in  W  pixel value.
- `x_sof`  in  1  start of frame; qualified by the handshake, marks pixel (0,0).
- `threshold`  in  W  binarisation threshold; latched on the first pixel of each frame.
- `detection_valid`  out  1  one-cycle pulse when results update.
- `crossing_detected`  out  1  decision for the last complete frame.
- `stripe_count`  out  CNT_W  maximum stripe count over all scan lines.
- `lines_agree`  out  $clog2(NUM_LINES+1)  number of lines whose count lies in [MIN_STRIPES, MAX_STRIPES].

## Operation
- **Scan rows.** Scan line k (0-based) is row (k+1)*IMG_HEIGHT/(NUM_LINES+1), using integer division fixed at elaboration. With H=16 and L=4 the rows are 3, 6, 9, 12.
- **Binarisation.** bit = (x_data >= thr_latched). On the first pixel of a frame, `threshold` itself is used and latched. Changes to `threshold` mid-frame are ignored.
- **Position counters.** `col` and `row` advance only on a handshake. `col` wraps at IMG_WIDTH-1 and increments `row`.
- **Run detection on a scan row.**
  - `run_len` counts consecutive 1-bits and saturates at MIN_RUN.
  - The pixel before col 0 is treated as 0.
  - A run closes on a 1→0 transition, or at col IMG_WIDTH-1 if the bit is still 1.
  - On close, if run_len >= MIN_RUN, increment `cnt[k]`, saturating at 2^CNT_W-1.
  - `run_len` clears at the start of every row.
- **Non-scan rows** only advance the position counters.
- **FSM states.** SCAN, EVAL, DONE.
  - SCAN: x_ready=1. The handshake on pixel (IMG_HEIGHT-1, IMG_WIDTH-1) moves to EVAL.
  - EVAL: x_ready=0. One line per cycle, NUM_LINES cycles: max-accumulate into the stripe maximum, increment the agree counter when the line's count is in range. Then go to DONE.
  - DONE: x_ready=0. Register `stripe_count`, `lines_agree`, and `crossing_detected` = (lines_agree >= MIN_AGREE). Pulse `detection_valid`. Clear all `cnt[k]` and position counters. Return to SCAN.
- **Frame resync.** An accepted `x_sof` while the position is not (0,0):
  - discard the partial frame (clear cnt, run_len, position);
  - treat that pixel as (0,0) of a new frame, latching the threshold;
  - produce no detection for the discarded frame.
- **x_sof at (0,0)** is a normal frame start.
- **Without x_sof**, frames are framed purely by the position counters.
- **Reset mid-frame** discards everything; the next accepted pixel is (0,0).

## Timing
- **Reset values.**
  - State SCAN, x_ready=1.
  - detection_valid, crossing_detected, stripe_count, lines_agree all 0.
  - All counters 0.
- **Latency.** If the last pixel handshake is at cycle T:
  - EVAL occupies T+1..T+NUM_LINES;
  - detection_valid=1 at T+NUM_LINES+1;
  - x_ready returns to 1 at T+NUM_LINES+2.
- **Backpressure.** x_ready is low for exactly NUM_LINES+1 cycles per frame. x_data/x_valid held by the source are accepted once x_ready rises.
- **Stall tolerance.** Gaps in x_valid have no effect on results.
- **Result stability.** Outputs hold stable between detection_valid pulses.

## Test plan
Directed tests use IMG 64x16, NUM_LINES=4, MIN_RUN=4, MIN_STRIPES=3, MAX_STRIPES=8, MIN_AGREE=3, threshold=128.

- **All-zero frame** → at T+5: detection_valid=1, stripe_count=0, lines_agree=0, crossing_detected=0; x_ready low for 5 cycles after the last pixel.
- **Every row 8×255 / 8×0 alternating** → stripe_count=4, lines_agree=4, crossing_detected=1; repeating this with random x_valid gaps gives identical results.
- **Runs of 3 ones (below MIN_RUN) on all rows** → stripe_count=0, crossing_detected=0. Edge runs at cols 0-3 and 60-63 only → stripe_count=2, lines_agree=0.
- **Stripes only on rows 3 and 6 (count 4 each)** → lines_agree=2, crossing_detected=0, stripe_count=4.
- **Threshold change and resync:**
  - threshold raised to 255 mid-frame → no effect on that frame;
  - x_sof asserted at row 7 → no detection_valid for the aborted frame;
  - the following full striped frame → crossing_detected=1.
- **rst_n low mid-frame, then a full striped frame** → all outputs 0 during reset; one detection_valid with crossing_detected=1 afterwards.

Source files
------------

// File: rtl/stripe_scanline_detector.sv
// Single-pass zebra-crossing detector: thresholds the pixel stream, counts long runs of
// 1-pixels on evenly spaced scan rows, and scores the frame once its last pixel arrives.
module stripe_scanline_detector #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int W           = 8,
  parameter int NUM_LINES   = 4,
  parameter int MIN_RUN     = 8,
  parameter int MIN_STRIPES = 4,
  parameter int MAX_STRIPES = 12,
  parameter int MIN_AGREE   = 3,
  parameter int CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_x_valid,
  output logic                             o_x_ready,
  input  logic [W-1:0]                     i_x_data,
  input  logic                             i_x_sof,
  input  logic [W-1:0]                     i_threshold,
  output logic                             o_detection_valid,
  output logic                             o_crossing_detected,
  output logic [CNT_W-1:0]                 o_stripe_count,
  output logic [$clog2(NUM_LINES+1)-1:0]   o_lines_agree
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int RUN_W = $clog2(MIN_RUN + 1);
  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int AGR_W = $clog2(NUM_LINES + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MIN_RUN);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0] CNT_LO    = CNT_W'(MIN_STRIPES);
  localparam logic [CNT_W-1:0] CNT_HI    = CNT_W'(MAX_STRIPES);
  localparam logic [AGR_W-1:0] AGREE_MIN = AGR_W'(MIN_AGREE);

  typedef enum logic [1:0] {SCAN, EVAL, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;

  logic [COL_W-1:0]   r_col;
  logic [COL_W-1:0]   w_col;
  logic [COL_W-1:0]   w_colNext;
  logic [ROW_W-1:0]   r_row;
  logic [ROW_W-1:0]   w_row;
  logic [ROW_W-1:0]   w_rowNext;
  logic [W-1:0]       r_thr;
  logic [W-1:0]       w_thr;
  logic               w_hs;
  logic               w_resync;
  logic               w_first;
  logic               w_bit;
  logic               w_lastPixel;
  logic               w_onScan;
  logic [IDX_W-1:0]   w_lineIdx;
  logic [RUN_W-1:0]   r_runLen;
  logic [RUN_W-1:0]   w_runBase;
  logic [RUN_W-1:0]   w_runInc;
  logic               w_stripeClose;
  logic [CNT_W-1:0]   r_cnt [NUM_LINES];

  logic [IDX_W-1:0]   r_evalIdx;
  logic               w_evalLast;
  logic [CNT_W-1:0]   w_lineCnt;
  logic [CNT_W-1:0]   r_maxAcc;
  logic [CNT_W-1:0]   w_maxNext;
  logic [AGR_W-1:0]   r_agreeAcc;
  logic [AGR_W-1:0]   w_agreeNext;

  logic               r_detValid;
  logic               r_crossing;
  logic [CNT_W-1:0]   r_stripeCount;
  logic [AGR_W-1:0]   r_linesAgree;

  assign o_detection_valid   = r_detValid;
  assign o_crossing_detected = r_crossing;
  assign o_stripe_count      = r_stripeCount;
  assign o_lines_agree       = r_linesAgree;

  // A sof away from (0,0) restarts the frame: the pixel itself is treated as (0,0).
  assign w_hs        = i_x_valid && (r_state == SCAN);
  assign w_resync    = w_hs && i_x_sof && ((r_col != '0) || (r_row != '0));
  assign w_col       = w_resync ? '0 : r_col;
  assign w_row       = w_resync ? '0 : r_row;
  assign w_first     = (w_col == '0) && (w_row == '0);
  assign w_thr       = w_first ? i_threshold : r_thr;
  assign w_bit       = (i_x_data >= w_thr);
  assign w_lastPixel = (w_row == ROW_LAST) && (w_col == COL_LAST);

  always_comb begin
    w_colNext = w_col + COL_W'(1);
    w_rowNext = w_row;
    if (w_col == COL_LAST) begin
      w_colNext = '0;
      w_rowNext = (w_row == ROW_LAST) ? '0 : w_row + ROW_W'(1);
    end
  end

  always_comb begin
    w_onScan  = 1'b0;
    w_lineIdx = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (w_row == ROW_W'((k + 1) * IMG_HEIGHT / (NUM_LINES + 1))) begin
        w_onScan  = 1'b1;
        w_lineIdx = IDX_W'(k);
      end
    end
  end

  // run_len saturates at MIN_RUN, so "long enough" is simply "saturated".
  assign w_runBase     = (w_col == '0) ? '0 : r_runLen;
  assign w_runInc      = (w_runBase == RUN_SAT) ? w_runBase : w_runBase + RUN_W'(1);
  assign w_stripeClose = w_bit ? ((w_col == COL_LAST) && (w_runInc == RUN_SAT))
                               : (w_runBase == RUN_SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    o_x_ready   = 1'b0;
    case (r_state)
      SCAN: begin
        o_x_ready = 1'b1;
        if (w_hs && w_lastPixel) w_stateNext = EVAL;
      end
      EVAL: begin
        if (w_evalLast) w_stateNext = DONE;
      end
      DONE: begin
        w_stateNext = SCAN;
      end
      default: begin
        w_stateNext = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_thr    <= '0;
      r_runLen <= '0;
      for (int k = 0; k < NUM_LINES; k++) r_cnt[k] <= '0;
    end else if (r_state == DONE) begin
      r_col    <= '0;
      r_row    <= '0;
      r_runLen <= '0;
      for (int k = 0; k < NUM_LINES; k++) r_cnt[k] <= '0;
    end else if (w_hs) begin
      r_col    <= w_colNext;
      r_row    <= w_rowNext;
      r_runLen <= (w_onScan && w_bit) ? w_runInc : '0;
      if (w_first) r_thr <= i_threshold;
      if (w_resync) begin
        for (int k = 0; k < NUM_LINES; k++) r_cnt[k] <= '0;
      end
      if (w_onScan && w_stripeClose && (r_cnt[w_lineIdx] != '1)) begin
        r_cnt[w_lineIdx] <= r_cnt[w_lineIdx] + CNT_W'(1);
      end
    end
  end

  // Evaluation walks one scan line per cycle; the last step publishes the results.
  assign w_evalLast  = (r_evalIdx == IDX_LAST);
  assign w_lineCnt   = r_cnt[r_evalIdx];
  assign w_maxNext   = (w_lineCnt > r_maxAcc) ? w_lineCnt : r_maxAcc;
  assign w_agreeNext = r_agreeAcc +
                       (((w_lineCnt >= CNT_LO) && (w_lineCnt <= CNT_HI)) ? AGR_W'(1) : AGR_W'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evalIdx     <= '0;
      r_maxAcc      <= '0;
      r_agreeAcc    <= '0;
      r_detValid    <= 1'b0;
      r_crossing    <= 1'b0;
      r_stripeCount <= '0;
      r_linesAgree  <= '0;
    end else begin
      r_detValid <= 1'b0;
      if (r_state == EVAL) begin
        r_evalIdx  <= r_evalIdx + IDX_W'(1);
        r_maxAcc   <= w_maxNext;
        r_agreeAcc <= w_agreeNext;
        if (w_evalLast) begin
          r_stripeCount <= w_maxNext;
          r_linesAgree  <= w_agreeNext;
          r_crossing    <= (w_agreeNext >= AGREE_MIN);
          r_detValid    <= 1'b1;
        end
      end else begin
        r_evalIdx  <= '0;
        r_maxAcc   <= '0;
        r_agreeAcc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stripe_scanline_detector.sv
// Randomised and directed bench for stripe_scanline_detector on a 64x16 frame, scored
// against a per-row run-length reference computed directly from the frame contents.
module tb_stripe_scanline_detector;

  localparam int IMG_W    = 64;
  localparam int IMG_H    = 16;
  localparam int NL       = 4;
  localparam int MINRUN   = 4;
  localparam int MINS     = 3;
  localparam int MAXS     = 8;
  localparam int MINAGREE = 3;
  localparam int CNTW     = 8;
  localparam int AGRW     = $clog2(NL + 1);
  localparam int NPIX     = IMG_W * IMG_H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            xValid = 1'b0;
  logic            xSof = 1'b0;
  logic [7:0]      xData = 8'd0;
  logic [7:0]      thrIn = 8'd128;
  logic            oXReady;
  logic            oDetValid;
  logic            oCrossing;
  logic [CNTW-1:0] oStripeCount;
  logic [AGRW-1:0] oLinesAgree;

  int checks = 0;
  int failures = 0;
  int detCount = 0;
  int prevCount = 0;
  int prevAgree = 0;
  int prevCross = 0;
  logic [7:0] pix [IMG_H][IMG_W];

  stripe_scanline_detector #(
    .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H), .W(8), .NUM_LINES(NL), .MIN_RUN(MINRUN),
    .MIN_STRIPES(MINS), .MAX_STRIPES(MAXS), .MIN_AGREE(MINAGREE), .CNT_W(CNTW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_x_valid(xValid),
    .o_x_ready(oXReady),
    .i_x_data(xData),
    .i_x_sof(xSof),
    .i_threshold(thrIn),
    .o_detection_valid(oDetValid),
    .o_crossing_detected(oCrossing),
    .o_stripe_count(oStripeCount),
    .o_lines_agree(oLinesAgree)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (oDetValid) detCount++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Stripe = a maximal run of at least MINRUN pixels at or above thr, judged at its last pixel.
  task automatic computeExpected(input logic [7:0] thr, output int eCount, output int eAgree,
                                 output int eCross);
    eCount = 0;
    eAgree = 0;
    for (int k = 0; k < NL; k++) begin
      int row;
      int stripes;
      row = (k + 1) * IMG_H / (NL + 1);
      stripes = 0;
      for (int c = 0; c < IMG_W; c++) begin
        bit endsHere;
        bit longEnough;
        endsHere = (pix[row][c] >= thr) && ((c == IMG_W - 1) || (pix[row][c + 1] < thr));
        longEnough = (c >= MINRUN - 1);
        for (int j = 0; j < MINRUN; j++) begin
          if (c - j >= 0 && pix[row][c - j] < thr) longEnough = 1'b0;
        end
        if (endsHere && longEnough) stripes++;
      end
      if (stripes > 255) stripes = 255;
      if (stripes > eCount) eCount = stripes;
      if (stripes >= MINS && stripes <= MAXS) eAgree++;
    end
    eCross = (eAgree >= MINAGREE) ? 1 : 0;
  endtask

  task automatic fillPeriodic(input int onLen, input int period, input logic [7:0] hi);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = ((c % period) < onLen) ? hi : 8'd0;
  endtask

  task automatic fillRandom(input logic [7:0] thr);
    for (int r = 0; r < IMG_H; r++) begin
      int c;
      bit level;
      c = 0;
      level = 1'($urandom_range(1));
      while (c < IMG_W) begin
        int len;
        len = int'($urandom_range(9, 1));
        for (int j = 0; j < len && c < IMG_W; j++) begin
          pix[r][c] = level ? 8'($urandom_range(255, int'(thr)))
                            : 8'($urandom_range(int'(thr) - 1, 0));
          c++;
        end
        level = ~level;
      end
    end
  endtask

  task automatic pushPixel(input logic [7:0] d, input logic sof, input int gap);
    int budget;
    xValid = 1'b0;
    xSof = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    xValid = 1'b1;
    xData = d;
    xSof = sof;
    budget = 0;
    while (!oXReady && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!oXReady) checkOutput("readyTimeout", 0, 1);
    @(posedge clk);
    #1;
    xValid = 1'b0;
    xSof = 1'b0;
  endtask

  task automatic applyStimulus(input int firstIdx, input int lastIdx, input int gapPct,
                               input bit sofAtStart, input logic [7:0] thr, input int thrChangeAt);
    thrIn = thr;
    for (int idx = firstIdx; idx <= lastIdx; idx++) begin
      int gap;
      if (idx == thrChangeAt) thrIn = 8'hFF;
      gap = (int'($urandom_range(99)) < gapPct) ? int'($urandom_range(3, 1)) : 0;
      pushPixel(pix[idx / IMG_W][idx % IMG_W], sofAtStart && (idx == firstIdx), gap);
    end
  endtask

  // Called one step after the edge that accepted the frame's last pixel.
  task automatic checkFrame(input string name, input logic [7:0] thr);
    int eCount;
    int eAgree;
    int eCross;
    int detBefore;
    computeExpected(thr, eCount, eAgree, eCross);
    detBefore = detCount;
    checkOutput({name, ".holdCount"}, int'(oStripeCount), prevCount);
    checkOutput({name, ".holdAgree"}, int'(oLinesAgree), prevAgree);
    checkOutput({name, ".holdCross"}, int'(oCrossing), prevCross);
    for (int i = 1; i <= NL + 1; i++) begin
      checkOutput({name, ".readyLow"}, int'(oXReady), 0);
      checkOutput({name, ".detPulse"}, int'(oDetValid), (i == NL + 1) ? 1 : 0);
      if (i == NL + 1) begin
        checkOutput({name, ".stripeCount"}, int'(oStripeCount), eCount);
        checkOutput({name, ".linesAgree"}, int'(oLinesAgree), eAgree);
        checkOutput({name, ".crossing"}, int'(oCrossing), eCross);
      end
      @(posedge clk);
      #1;
    end
    checkOutput({name, ".readyBack"}, int'(oXReady), 1);
    checkOutput({name, ".detDrop"}, int'(oDetValid), 0);
    checkOutput({name, ".detOnce"}, detCount - detBefore, 1);
    prevCount = eCount;
    prevAgree = eAgree;
    prevCross = eCross;
  endtask

  initial begin
    int detMark;
    logic [7:0] thr;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.ready", int'(oXReady), 1);
    checkOutput("reset.det", int'(oDetValid), 0);
    checkOutput("reset.cross", int'(oCrossing), 0);
    checkOutput("reset.count", int'(oStripeCount), 0);
    checkOutput("reset.agree", int'(oLinesAgree), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fillPeriodic(0, 16, 8'd255);
    applyStimulus(0, NPIX - 1, 0, 1'b1, 8'd128, -1);
    checkFrame("zero", 8'd128);

    fillPeriodic(8, 16, 8'd255);
    applyStimulus(0, NPIX - 1, 0, 1'b1, 8'd128, -1);
    checkFrame("stripes", 8'd128);
    applyStimulus(0, NPIX - 1, 40, 1'b1, 8'd128, -1);
    checkFrame("stripesGaps", 8'd128);

    fillPeriodic(3, 8, 8'd255);
    applyStimulus(0, NPIX - 1, 10, 1'b1, 8'd128, -1);
    checkFrame("shortRuns", 8'd128);

    fillPeriodic(0, 16, 8'd255);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < 4; c++) begin
        pix[r][c] = 8'd255;
        pix[r][IMG_W - 1 - c] = 8'd255;
      end
    end
    applyStimulus(0, NPIX - 1, 10, 1'b1, 8'd128, -1);
    checkFrame("edgeRuns", 8'd128);

    fillPeriodic(8, 16, 8'd255);
    for (int r = 0; r < IMG_H; r++)
      if (r != 3 && r != 6)
        for (int c = 0; c < IMG_W; c++) pix[r][c] = 8'd0;
    applyStimulus(0, NPIX - 1, 10, 1'b1, 8'd128, -1);
    checkFrame("rows3and6", 8'd128);

    fillPeriodic(8, 16, 8'd200);
    applyStimulus(0, NPIX - 1, 10, 1'b1, 8'd128, 500);
    checkFrame("thrMidFrame", 8'd128);

    fillPeriodic(4, 8, 8'd255);
    detMark = detCount;
    applyStimulus(0, 7 * IMG_W - 1, 20, 1'b1, 8'd200, -1);
    fillPeriodic(8, 16, 8'd150);
    applyStimulus(0, NPIX - 1, 20, 1'b1, 8'd128, -1);
    checkFrame("resync", 8'd128);
    checkOutput("resync.detTotal", detCount - detMark, 1);

    fillPeriodic(8, 16, 8'd255);
    applyStimulus(0, 400, 0, 1'b1, 8'd128, -1);
    rst_n = 1'b0;
    #2;
    checkOutput("midReset.ready", int'(oXReady), 1);
    checkOutput("midReset.det", int'(oDetValid), 0);
    checkOutput("midReset.cross", int'(oCrossing), 0);
    checkOutput("midReset.count", int'(oStripeCount), 0);
    checkOutput("midReset.agree", int'(oLinesAgree), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prevCount = 0;
    prevAgree = 0;
    prevCross = 0;
    detMark = detCount;
    applyStimulus(0, NPIX - 1, 10, 1'b0, 8'd128, -1);
    checkFrame("afterReset", 8'd128);
    checkOutput("afterReset.detTotal", detCount - detMark, 1);

    for (int f = 0; f < 8; f++) begin
      thr = 8'($urandom_range(215, 40));
      fillRandom(thr);
      applyStimulus(0, NPIX - 1, 25, 1'($urandom_range(1)), thr, int'($urandom_range(NPIX - 1, 1)));
      checkFrame("random", thr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
